rst_sequencer: RTL and testbench

- Parametrised successor to the two-stage core reset synchroniser in the system top.
- Synchronises an external active-low reset request into the core clock domain with a configurable number of stages.
- Releases N_CH downstream reset outputs in a fixed order, with a guaranteed hold time and per-step spacing.
- Supports software-initiated re-sequencing; sits between the SoC reset source and the core/uncore sub-blocks.

---
 rtl/rst_sequencer.sv | 110 +++++++++++
 tb/tb_rst_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// rst_sequencer: synchronised, ordered release of N_CH active-low resets; optional watchdog via RST_SEQ_WDT_EN
module rst_sequencer #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8,
   parameter int CNT_W       = 16,
   parameter int WDT_CYCLES  = 1024
) (
   input  logic            coreclk,
   input  logic            corerstn,
   input  logic            rst_req_n,
   input  logic            soft_rst,
   output logic [N_CH-1:0] rstn_out,
   output logic            busy,
   output logic            done
`ifdef RST_SEQ_WDT_EN
   ,
   input  logic            wdt_kick,
   output logic            wdt_fired
`endif
);
   localparam int     CH_W    = $clog2(N_CH + 1);
   localparam longint CNT_CAP = longint'(1) << CNT_W;
   typedef enum logic [1:0] {HOLD, STEP, RUN} state_t;
   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s, abort, wdt_to;
   logic [CNT_W-1:0]       cnt, cnt_nx;
   logic [CH_W-1:0]        ch, ch_nx;
   logic [N_CH-1:0]        rstn_nx;
   if (HOLD_CYCLES > CNT_CAP || STEP_CYCLES > CNT_CAP || WDT_CYCLES > CNT_CAP) begin : g_cnt_w_check
      $error("CNT_W too narrow for HOLD_CYCLES/STEP_CYCLES/WDT_CYCLES");
   end
   assign req_s = sync_q[SYNC_STAGES-1];
   // abort outranks any release that would fall on the same edge
   assign abort = !req_s || soft_rst || wdt_to;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ch_nx    = ch;
      rstn_nx  = rstn_out;
      if (abort) begin
         state_nx = HOLD;
         cnt_nx   = '0;
         ch_nx    = '0;
         rstn_nx  = '0;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                  state_nx = (N_CH == 1) ? RUN : STEP;
                  cnt_nx   = '0;
                  ch_nx    = CH_W'(1);
                  rstn_nx  = N_CH'(1);
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            STEP: begin
               if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
                  state_nx = (ch == CH_W'(N_CH - 1)) ? RUN : STEP;
                  cnt_nx   = '0;
                  ch_nx    = ch + CH_W'(1);
                  rstn_nx  = (rstn_out << 1) | N_CH'(1);
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nx = RUN;
            end
         endcase
      end
   end
   always_ff @(posedge coreclk) begin
      if (!corerstn) begin
         sync_q   <= '0;
         state    <= HOLD;
         cnt      <= '0;
         ch       <= '0;
         rstn_out <= '0;
         done     <= 1'b0;
         busy     <= 1'b1;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], rst_req_n};
         state    <= state_nx;
         cnt      <= cnt_nx;
         ch       <= ch_nx;
         rstn_out <= rstn_nx;
         done     <= &rstn_nx;
         busy     <= ~&rstn_nx;
      end
   end
`ifdef RST_SEQ_WDT_EN
   logic [CNT_W-1:0] wdt_cnt;
   assign wdt_to = (state == RUN) && !wdt_kick && (wdt_cnt == CNT_W'(WDT_CYCLES - 1));
   always_ff @(posedge coreclk) begin
      if (!corerstn) begin
         wdt_cnt   <= '0;
         wdt_fired <= 1'b0;
      end else begin
         wdt_cnt   <= (state == RUN && !abort && !wdt_kick) ? wdt_cnt + CNT_W'(1) : '0;
         wdt_fired <= wdt_to;
      end
   end
`else
   assign wdt_to = 1'b0;
`endif
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench for the default sequencer and a 1-channel, 1-cycle variant
`timescale 1ns/1ps
module tb_rst_sequencer;
   typedef struct {
      int         id;
      int         cyc;
      logic [3:0] rstn;
      logic       done;
      logic       busy;
   } exp_t;
   logic       coreclk = 1'b0, corerstn = 1'b0, rst_req_n = 1'b1, soft_rst = 1'b0;
   logic       cr2 = 1'b0, req2 = 1'b0, soft2 = 1'b0;
   logic [3:0] rstn_out;
   logic       busy, done;
   logic [0:0] rstn2;
   logic       busy2, done2;
   logic [3:0] prev1 = '0;
   logic       prev2 = 1'b0;
   int         cyc = 0, total = 0, bad = 0;
   exp_t       q[$];
   int         wq[$];
`ifdef RST_SEQ_WDT_EN
   logic wdt_kick = 1'b0, wdt_fired, kick2 = 1'b1, fired2;
`endif
   rst_sequencer #(.WDT_CYCLES(32)) dut (
      .coreclk(coreclk), .corerstn(corerstn), .rst_req_n(rst_req_n), .soft_rst(soft_rst),
      .rstn_out(rstn_out), .busy(busy), .done(done)
`ifdef RST_SEQ_WDT_EN
      , .wdt_kick(wdt_kick), .wdt_fired(wdt_fired)
`endif
   );
   rst_sequencer #(.N_CH(1), .HOLD_CYCLES(1), .STEP_CYCLES(1)) dut2 (
      .coreclk(coreclk), .corerstn(cr2), .rst_req_n(req2), .soft_rst(soft2),
      .rstn_out(rstn2), .busy(busy2), .done(done2)
`ifdef RST_SEQ_WDT_EN
      , .wdt_kick(kick2), .wdt_fired(fired2)
`endif
   );
   always #5 coreclk = ~coreclk;
   always @(posedge coreclk) cyc <= cyc + 1;
   task automatic tick(int n);
      repeat (n) @(posedge coreclk);
      #1;
   endtask
   task automatic cmp(string nm, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, req);
      end
   endtask
   task automatic push(int id, int c, logic [3:0] r, logic d, logic b);
      exp_t e;
      e.id   = id;
      e.cyc  = c;
      e.rstn = r;
      e.done = d;
      e.busy = b;
      q.push_back(e);
   endtask
   task automatic push_seq(int r0);
      push(1, r0,      4'b0001, 1'b0, 1'b1);
      push(1, r0 + 8,  4'b0011, 1'b0, 1'b1);
      push(1, r0 + 16, 4'b0111, 1'b0, 1'b1);
      push(1, r0 + 24, 4'b1111, 1'b1, 1'b0);
   endtask
   task automatic drain(int lim);
      for (int i = 0; i < lim && q.size() > 0; i++) tick(1);
      total++;
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain_timeout at cycle %0d: got %0d pending events want 0", cyc, q.size());
         q.delete();
      end
   endtask
   task automatic event_chk(int id, logic [3:0] r, logic d, logic b);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_edge dut%0d at cycle %0d: got rstn=%b want no change", id, cyc, r);
         return;
      end
      e = q.pop_front();
      cmp("event_dut", id, e.id);
      cmp("event_cycle", cyc, e.cyc);
      cmp("event_rstn", r, e.rstn);
      cmp("event_done", d, e.done);
      cmp("event_busy", b, e.busy);
   endtask
   function automatic logic therm(logic [3:0] v);
      logic [3:0] t;
      t = v + 4'd1;
      return (v & t) == 4'd0;
   endfunction
   always @(negedge coreclk) begin
      total++;
      if (!therm(rstn_out)) begin
         bad++;
         $display("FAIL thermometer at cycle %0d: got rstn_out=%b want thermometer code", cyc, rstn_out);
      end
      if (rstn_out != prev1) event_chk(1, rstn_out, done, busy);
      if (rstn2 != prev2) event_chk(2, {3'b000, rstn2}, done2, busy2);
      prev1 = rstn_out;
      prev2 = rstn2;
`ifdef RST_SEQ_WDT_EN
      if (wdt_fired) begin
         if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wdt_fire at cycle %0d: got 1 want 0", cyc);
         end else begin
            cmp("wdt_fire_cycle", cyc, wq.pop_front());
         end
      end
`endif
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by cycle %0d want finish", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      int a;
`ifdef RST_SEQ_WDT_EN
      int k;
      int r2;
`endif
      tick(5);
      cmp("reset_rstn", rstn_out, 0);
      cmp("reset_busy", busy, 1);
      cmp("reset_done", done, 0);
      corerstn = 1'b1;
      cr2      = 1'b1;
      push_seq(cyc + 18);
      drain(80);
      a = cyc + 1;
      soft_rst = 1'b1;
      push(1, a, 4'b0000, 1'b0, 1'b1);
      push_seq(a + 16);
      tick(1);
      soft_rst = 1'b0;
      drain(80);
      a = cyc + 1;
      soft_rst = 1'b1;
      push(1, a, 4'b0000, 1'b0, 1'b1);
      push_seq(a + 29);
      tick(1);
      soft_rst = 1'b0;
      while (cyc < a + 10) tick(1);
      rst_req_n = 1'b0;
      tick(1);
      rst_req_n = 1'b1;
      drain(100);
      a = cyc + 1;
      soft_rst = 1'b1;
      push(1, a, 4'b0000, 1'b0, 1'b1);
      push(1, a + 16, 4'b0001, 1'b0, 1'b1);
      push(1, a + 24, 4'b0011, 1'b0, 1'b1);
      tick(1);
      soft_rst = 1'b0;
      while (cyc < a + 26) tick(1);
      corerstn = 1'b0;
      push(1, cyc + 1, 4'b0000, 1'b0, 1'b1);
      tick(1);
      corerstn = 1'b1;
      push_seq(cyc + 18);
      drain(100);
`ifdef RST_SEQ_WDT_EN
      for (int i = 0; i < 5; i++) begin
         tick(19);
         wdt_kick = 1'b1;
         tick(1);
         wdt_kick = 1'b0;
      end
      k = cyc;
      wq.push_back(k + 32);
      push(1, k + 32, 4'b0000, 1'b0, 1'b1);
      push_seq(k + 48);
      r2 = k + 72;
      drain(150);
      while (cyc < r2 + 31) tick(1);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      wq.push_back(r2 + 64);
      push(1, r2 + 64, 4'b0000, 1'b0, 1'b1);
      push_seq(r2 + 80);
      drain(200);
      cmp("wdt_queue_empty", wq.size(), 0);
`endif
      req2 = 1'b1;
      push(2, cyc + 3, 4'b0001, 1'b1, 1'b0);
      drain(20);
      req2 = 1'b0;
      push(2, cyc + 3, 4'b0000, 1'b0, 1'b1);
      drain(20);
      req2 = 1'b1;
      push(2, cyc + 3, 4'b0001, 1'b1, 1'b0);
      drain(20);
      soft2 = 1'b1;
      push(2, cyc + 1, 4'b0000, 1'b0, 1'b1);
      push(2, cyc + 2, 4'b0001, 1'b1, 1'b0);
      tick(1);
      soft2 = 1'b0;
      drain(20);
      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
